// File: rtl/mod_148_4_4_timer_pkg.sv
// Shared constants, state encoding and helpers for the timer bank.
package mod_148_4_4_timer_pkg;

  localparam int NOM_BEACON_NS         = 2000;
  localparam int NOM_BEACON_DET_NS     = 2200;
  localparam int NOM_INVALID_BEACON_NS = 4000;
  localparam int NOM_BURST_NS          = 12800;
  localparam int NOM_TO_NS             = 3200;
  localparam int NOM_APPEND_COMMIT_NS  = 2200;

  localparam int NUM_TMR           = 6;
  localparam int TMR_BEACON        = 0;
  localparam int TMR_BEACON_DET    = 1;
  localparam int TMR_INVALID_BEACON = 2;
  localparam int TMR_BURST         = 3;
  localparam int TMR_TO            = 4;
  localparam int TMR_APPEND_COMMIT = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tmr_state_e;

  function automatic int ceil_div(int num, int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/mod_148_4_4_timer_bank_if.sv
// Timer request/status bundle between the PLCA controller and the timer bank.
// The expiry pulse vector exists only with MOD_148_TIMER_EXPIRE_PULSE_EN.
interface mod_148_4_4_timer_bank_if;
  logic [5:0] timer_start;
  logic [5:0] timer_stop;
  logic [5:0] timer_done;
  logic [5:0] timer_not_done;
`ifdef MOD_148_TIMER_EXPIRE_PULSE_EN
  logic [5:0] timer_expired;

  modport master (output timer_start, output timer_stop,
                  input timer_done, input timer_not_done, input timer_expired);
  modport slave  (input timer_start, input timer_stop,
                  output timer_done, output timer_not_done, output timer_expired);
`else
  modport master (output timer_start, output timer_stop,
                  input timer_done, input timer_not_done);
  modport slave  (input timer_start, input timer_stop,
                  output timer_done, output timer_not_done);
`endif
endinterface

// File: rtl/mod_148_4_4_timer_chan.sv
// One clock-counted timer channel: IDLE / RUN / DONE with retrigger and abort.
// Optional expiry pulse output under MOD_148_TIMER_EXPIRE_PULSE_EN.
module mod_148_4_4_timer_chan
  import mod_148_4_4_timer_pkg::*;
#(
  parameter int N     = 1,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stop,
  output logic done,
  output logic not_done
`ifdef MOD_148_TIMER_EXPIRE_PULSE_EN
  ,output logic expired
`endif
);

  if (N < 1 || longint'(N) >= (longint'(1) << CNT_W)) begin : g_bad_n
    $error("timer_chan: cycle count N=%0d does not fit CNT_W=%0d", N, CNT_W);
  end

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(N - 1);

  tmr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = ST_RUN;
      cnt_d   = LOAD;
    end else if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (cnt_q == '0) state_d = ST_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Status flags are flopped from the next state so outputs are pure registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      done     <= 1'b0;
      not_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done     <= (state_d == ST_DONE);
      not_done <= (state_d == ST_RUN);
    end
  end

`ifdef MOD_148_TIMER_EXPIRE_PULSE_EN
  logic fire;
  assign fire = (state_q == ST_RUN) && (cnt_q == '0) && !start && !stop;

  always_ff @(posedge clk) begin
    if (reset) expired <= 1'b0;
    else       expired <= fire;
  end
`endif

endmodule

// File: rtl/mod_148_4_4_timer_bank.sv
// Bank of six independent 802.3 Clause 148 timers counted in clk cycles.
// Define MOD_148_TIMER_EXPIRE_PULSE_EN to add the per-timer expiry pulse.
module mod_148_4_4_timer_bank
  import mod_148_4_4_timer_pkg::*;
#(
  parameter int CLK_PERIOD_NS     = 40,
  parameter int BEACON_NS         = NOM_BEACON_NS,
  parameter int BEACON_DET_NS     = NOM_BEACON_DET_NS,
  parameter int INVALID_BEACON_NS = NOM_INVALID_BEACON_NS,
  parameter int BURST_NS          = NOM_BURST_NS,
  parameter int TO_NS             = NOM_TO_NS,
  parameter int APPEND_COMMIT_NS  = NOM_APPEND_COMMIT_NS,
  parameter int CNT_W             = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  mod_148_4_4_timer_bank_if.slave tmr
);

  function automatic int chan_ns(int idx);
    case (idx)
      TMR_BEACON:         return BEACON_NS;
      TMR_BEACON_DET:     return BEACON_DET_NS;
      TMR_INVALID_BEACON: return INVALID_BEACON_NS;
      TMR_BURST:          return BURST_NS;
      TMR_TO:             return TO_NS;
      default:            return APPEND_COMMIT_NS;
    endcase
  endfunction

  logic [NUM_TMR-1:0] done_v, not_done_v;
`ifdef MOD_148_TIMER_EXPIRE_PULSE_EN
  logic [NUM_TMR-1:0] expired_v;
`endif

  for (genvar i = 0; i < NUM_TMR; i++) begin : g_chan
    mod_148_4_4_timer_chan #(
      .N     (ceil_div(chan_ns(i), CLK_PERIOD_NS)),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .start    (tmr.timer_start[i]),
      .stop     (tmr.timer_stop[i]),
      .done     (done_v[i]),
      .not_done (not_done_v[i])
`ifdef MOD_148_TIMER_EXPIRE_PULSE_EN
      ,.expired (expired_v[i])
`endif
    );
  end

  assign tmr.timer_done     = done_v;
  assign tmr.timer_not_done = not_done_v;
`ifdef MOD_148_TIMER_EXPIRE_PULSE_EN
  assign tmr.timer_expired  = expired_v;
`endif

endmodule

// File: doc/mod_148_4_4_timer_bank.md
Name: mod_148_4_4_timer_bank

Overview:
- Synthesizable, clock-counted implementation of the six Clause 148.4.4 timers: beacon, beacon_det, invalid_beacon, burst, to, append_commit.
- Sits on the controller side of the timer interface. PLCA/multidrop state machines drive start/stop requests; the block returns timer_done/timer_not_done levels with IEEE 802.3 timer semantics.
- Replaces simulation-only delay timers on the synthesis path.

Parameters:
- CLK_PERIOD_NS, 40, clock period in ns (25 MHz MII clock).
- BEACON_NS, 2000, beacon_timer nominal duration.
- BEACON_DET_NS, 2200, beacon_det_timer nominal duration.
- INVALID_BEACON_NS, 4000, invalid_beacon_timer nominal duration.
- BURST_NS, 12800, burst_timer nominal duration.
- TO_NS, 3200, to_timer nominal duration.
- APPEND_COMMIT_NS, 2200, append_commit_timer nominal duration.
- CNT_W, 16, counter width; must hold the largest cycle count.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- timer_start  input  6  per-timer start request, level sampled each cycle. Bit index: 0 beacon, 1 beacon_det, 2 invalid_beacon, 3 burst, 4 to, 5 append_commit.
- timer_stop  input  6  per-timer abort request, same index map.
- timer_done  output  6  per-timer expired level.
- timer_not_done  output  6  per-timer running level.
- timer_expired  output  6  one-cycle expiry pulse. Present only with the optional feature.

Behaviour:
- Cycle count per timer: N = ceil(X_NS / CLK_PERIOD_NS), computed at elaboration. Defaults give 50, 55, 100, 320, 80, 55.
- Elaboration error if N < 1 or N >= 2^CNT_W.
- Each channel has 3 states: IDLE (done=0, not_done=0), RUN (done=0, not_done=1), DONE (done=1, not_done=0).
- Reset applies at the next clk edge while reset=1. All channels go to IDLE, counters to 0, all outputs 0.
- Reset overrides start and stop, including mid-RUN.
- start sampled high in any state:
  - load counter = N-1 and enter RUN;
  - not_done=1 on the next cycle.
- In RUN with no start or stop, the counter decrements each cycle.
- Expiry: when the counter is 0 and neither start nor stop is asserted, the channel enters DONE.
- Timing: start sampled at edge k gives not_done high for exactly N cycles, then done high from edge k+N.
- DONE persists until start, stop, or reset.
- Restart while in RUN reloads N-1; remaining time is discarded (retrigger).
- start held high continuously keeps the channel in RUN indefinitely. Callers pulse start for one cycle.
- stop sampled high: go to IDLE (done=0, not_done=0), counter cleared.
- start and stop high in the same cycle: start wins (reload, RUN).
- done and not_done are never both 1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Channels are fully independent; simultaneous events on different channels do not interact.

Optional Feature:
- Macro: MOD_148_TIMER_EXPIRE_PULSE_EN.
- Defined: adds the timer_expired[5:0] port. Bit i is high for exactly one cycle, the same cycle timer_done[i] first rises from RUN.
  - No pulse on stop, reset, or restart.
  - No pulse when re-entering DONE would not occur (a restart always goes to RUN).
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package/include `mod_148_4_4_timer_pkg` holds:
  - the six nominal ns constants;
  - the bit-index constants (TMR_BEACON=0 … TMR_APPEND_COMMIT=5);
  - the ceil-divide function;
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One sub-module, `mod_148_4_4_timer_chan`:
  - parameterized by N and CNT_W;
  - ports clk, reset, start, stop, done, not_done, expired;
  - instantiated six times via generate.

Test Plan:
1. Reset, then single-cycle timer_start[0] at edge k → timer_not_done[0]=1 for cycles k+1..k+50, timer_done[0]=1 from k+50. Other bits remain 0.
2. Pulse timer_start[3]; pulse it again at k+200 → done first rises at k+200+320 = k+520, not k+320.
3. Pulse timer_start[4]; assert timer_stop[4] at k+40 → both outputs 0 from k+41; done never rises.
4. timer_start[2] and timer_stop[2] together at edge k → RUN; done at k+100.
5. Start all six at edge k → done rises at k+50, 55, 100, 320, 80, 55. Bits 1 and 5 rise together. With MOD_148_TIMER_EXPIRE_PULSE_EN, each timer_expired bit pulses exactly once, in the matching cycle.
6. Start timer 5; assert reset at k+30 → all outputs 0 at k+31. A start at k+31 is ignored if reset is still high; a start after reset deasserts times the full 55 cycles.
